lagarto_plic_target_arbiter: RTL and testbench
==============================================

Name: lagarto_plic_target_arbiter

Overview:
- Per-target PLIC arbiter: reduces NUM_SOURCES pending/enabled interrupt sources to the single highest-priority source ID and priority.
- Compares the winner against the target's threshold to drive the external interrupt pending (EIP) line.
- Generalises the two-input priority multiplexer into a parametrised comparison tree, with optional per-level pipelining, selectable tie-break, a pipeline-fill valid flag and threshold gating.
- Sits between the gateway/pending array and the per-target claim/complete register file.

Parameters:
- NUM_SOURCES, 31, number of interrupt sources; IDs 1..NUM_SOURCES; ID 0 = NO_INTERRUPT.
- PRIORITY_WIDTH, 3, width of each priority and of the threshold.
- ID_WIDTH, $clog2(NUM_SOURCES+1), width of source IDs (derived; do not override).
- PIPELINED, 0, 0 = combinational tree plus one output register; 1 = register after every tree level.
- TIE_BREAK_LOWEST_ID, 0, 0 = equal priorities resolve to greater ID (legacy behaviour); 1 = lower ID (PLIC spec).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- pending_i  in  NUM_SOURCES  bit k-1 = source k pending.
- enable_i  in  NUM_SOURCES  bit k-1 = source k enabled for this target.
- priorities_i  in  NUM_SOURCES*PRIORITY_WIDTH  source k priority at [(k-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH].
- threshold_i  in  PRIORITY_WIDTH  target priority threshold.
- max_priority_o  out  PRIORITY_WIDTH  winning priority (0 if none).
- max_id_o  out  ID_WIDTH  winning ID (0 if none).
- eip_o  out  1  external interrupt pending to hart.
- valid_o  out  1  pipeline filled; outputs reflect sampled inputs.

Behaviour:
- Leaves: D = max(1, $clog2(NUM_SOURCES+1)); 2^D leaves.
  - Leaf 0 is constant (prio 0, ID 0).
  - Leaf k (1 ≤ k ≤ NUM_SOURCES) is eligible iff pending & enable & priority != 0. If eligible it carries (priority, k); otherwise (0, 0).
  - Padding leaves are (0, 0).
- Node compare on (pa, ia) vs (pb, ib):
  - Strictly higher priority wins.
  - On equal nonzero priority, the winner is the greater ID, or the lower ID if TIE_BREAK_LOWEST_ID = 1.
  - Equal priority 0 gives (0, 0). NO_INTERRUPT never wins over a real source.
- Winner is independent of tree shape: the result equals a global max with the tie-break rule.
- All compares are unsigned. No truncation; IDs are zero-extended to ID_WIDTH.
- Latency LAT = 1 if PIPELINED = 0, else D. Inputs sampled at edge n appear on max_priority_o / max_id_o after edge n+LAT-1. Example: default NUM_SOURCES=31, PIPELINED=1 gives D=5, LAT=5.
- Every stage register holds (priority, ID) pairs only; there is no stall and no backpressure. Inputs are sampled every cycle.
- eip_o = valid_o & (max_priority_o > threshold_i):
  - Combinational from the registered winner and the live threshold.
  - Strictly greater: priority equal to threshold gives no EIP.
  - threshold_i = 2^PRIORITY_WIDTH-1 masks all sources.
- Fill counter: saturating, width $clog2(LAT+1).
  - Resets to 0 and increments each cycle until it reaches LAT.
  - valid_o = (count == LAT), i.e. asserts on the LAT-th rising edge after reset release.
- Reset (async assert, released to the clock by the system):
  - All stage registers → (0, 0); count → 0.
  - Outputs: max_priority_o = 0, max_id_o = 0, eip_o = 0, valid_o = 0.
  - Reset mid-operation discards all in-flight winners immediately.
- Simultaneous input change: each sampled input vector propagates independently. With PIPELINED=1, consecutive cycles' results emerge on consecutive cycles, with no mixing between cycles.
- Priority changes on a pending source take effect LAT cycles later. No hysteresis.

Test Plan:
- Reset: hold rstn_i low, toggle all inputs → all outputs 0. Release with PIPELINED=1, 31 sources → valid_o rises exactly 5 edges later, stays 1.
- Single source: source 7 pending+enabled, prio 3, threshold 2 → after LAT: max_id_o=7, max_priority_o=3, eip_o=1. Threshold changed to 3 → eip_o=0 the same cycle, ID still 7.
- Ties: sources 4 and 20 both prio 5. TIE_BREAK_LOWEST_ID=0 → ID 20; =1 → ID 4. Source 9 at prio 6 added → ID 9.
- Masking: source 12 pending prio 7 but enable=0; source 3 enabled prio 0 → max_id_o=0, max_priority_o=0, eip_o=0. Enable 12 → ID 12, prio 7.
- Pipeline streaming (PIPELINED=1): change winner each cycle to IDs 1, 2, 3, 4 with prio 1 → outputs 1, 2, 3, 4 on consecutive cycles, starting LAT after first sample. Assert reset mid-stream → outputs 0 asynchronously, valid_o=0 until refill.
- Random: 10k cycles, random pending/enable/priorities/threshold, NUM_SOURCES ∈ {1, 5, 31, 63}, both PIPELINED values → match reference model (global max, tie rule) delayed by LAT.

Source files
------------

// File: rtl/lagarto_plic_target_arbiter.sv
// Per-target PLIC arbiter: reduces the pending & enabled interrupt sources to
// the single highest-priority (priority, ID) pair through a binary comparison
// tree. The tree is either combinational with one output register, or it has
// a register after every level. EIP is raised when the winner beats the
// target threshold.
module lagarto_plic_target_arbiter #(
    parameter int NUM_SOURCES         = 31,
    parameter int PRIORITY_WIDTH      = 3,
    parameter int ID_WIDTH            = $clog2(NUM_SOURCES + 1),
    parameter int PIPELINED           = 0,
    parameter int TIE_BREAK_LOWEST_ID = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [NUM_SOURCES-1:0]                pending_i,
    input  logic [NUM_SOURCES-1:0]                enable_i,
    input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0] priorities_i,
    input  logic [PRIORITY_WIDTH-1:0]             threshold_i,
    output logic [PRIORITY_WIDTH-1:0]             max_priority_o,
    output logic [ID_WIDTH-1:0]                   max_id_o,
    output logic                                  eip_o,
    output logic                                  valid_o
);

    // Tree geometry: DEPTH levels over 2^DEPTH leaves. Leaf 0 is the constant
    // NO_INTERRUPT entry, leaves above NUM_SOURCES are padding.
    localparam int LOG_SRC = $clog2(NUM_SOURCES + 1);
    localparam int DEPTH   = (LOG_SRC > 1) ? LOG_SRC : 1;
    localparam int NLEAF   = 1 << DEPTH;
    localparam int NINT    = NLEAF - 1;
    localparam int NNODE   = 2 * NLEAF - 1;
    localparam int LAT     = (PIPELINED != 0) ? DEPTH : 1;
    localparam int CNT_W   = $clog2(LAT + 1);

    typedef struct packed {
        logic [PRIORITY_WIDTH-1:0] prio;
        logic [ID_WIDTH-1:0]       id;
    } cand_t;

    // Two-candidate compare. A strictly higher priority wins; equal nonzero
    // priorities fall back to the ID tie-break. A zero-priority result is
    // always normalised to NO_INTERRUPT so ID 0 can never be beaten by a
    // stray ID carried with priority 0.
    function automatic cand_t merge(input cand_t a, input cand_t b);
        cand_t w;
        if (a.prio != b.prio) begin
            w = (a.prio > b.prio) ? a : b;
        end else if (TIE_BREAK_LOWEST_ID != 0) begin
            w = (a.id < b.id) ? a : b;
        end else begin
            w = (a.id > b.id) ? a : b;
        end
        if (w.prio == '0) begin
            w = '0;
        end
        return w;
    endfunction

    cand_t leaf    [NLEAF];
    cand_t node_d  [NINT];
    cand_t root;

    // Leaf qualification: a source competes only if pending, enabled and of
    // nonzero priority; everything else enters the tree as NO_INTERRUPT.
    always_comb begin
        for (int j = 0; j < NLEAF; j++) begin
            leaf[j] = '0;
        end
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            if (pending_i[k-1] && enable_i[k-1] &&
                (priorities_i[(k-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH] != '0)) begin
                leaf[k].prio = priorities_i[(k-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH];
                leaf[k].id   = ID_WIDTH'(k);
            end
        end
    end

    // Heap layout: node i has children 2i+1 and 2i+2; leaves occupy heap
    // slots NINT .. NNODE-1 and the root is node 0.
    generate
        if (PIPELINED != 0) begin : g_pipe
            cand_t node_q [NINT];
            cand_t tap    [1:NNODE-1];

            // Every node compares the registered winners of its children.
            always_comb begin
                for (int j = 0; j < NLEAF; j++) begin
                    tap[NINT+j] = leaf[j];
                end
                for (int i = 1; i < NINT; i++) begin
                    tap[i] = node_q[i];
                end
                for (int i = 0; i < NINT; i++) begin
                    node_d[i] = merge(tap[2*i+1], tap[2*i+2]);
                end
            end

            // One register per tree node; in-flight winners are dropped on reset.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < NINT; i++) begin
                        node_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NINT; i++) begin
                        node_q[i] <= node_d[i];
                    end
                end
            end

            assign root = node_q[0];
        end else begin : g_comb
            cand_t tap [1:NNODE-1];
            cand_t root_q;

            // Resolve the whole tree in one pass, children before parents.
            always_comb begin
                for (int j = 0; j < NLEAF; j++) begin
                    tap[NINT+j] = leaf[j];
                end
                for (int i = NINT - 1; i >= 0; i--) begin
                    node_d[i] = merge(tap[2*i+1], tap[2*i+2]);
                    if (i > 0) begin
                        tap[i] = node_d[i];
                    end
                end
            end

            // Single output register holding the tree result.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    root_q <= '0;
                end else begin
                    root_q <= node_d[0];
                end
            end

            assign root = root_q;
        end
    endgenerate

    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;

    // Fill counter saturates once the first sampled vector reaches the root.
    always_comb begin
        fill_d = fill_q;
        if (fill_q != CNT_W'(LAT)) begin
            fill_d = fill_q + CNT_W'(1);
        end
    end

    // Fill counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign valid_o        = (fill_q == CNT_W'(LAT));
    assign max_priority_o = root.prio;
    assign max_id_o       = root.id;
    // Threshold is live so software sees masking take effect immediately.
    assign eip_o          = valid_o && (root.prio > threshold_i);

endmodule

// File: tb/tb_lagarto_plic_target_arbiter.sv
// Bench for lagarto_plic_target_arbiter: several configurations side by side,
// all fed the same stimulus and compared against a global-max reference.
module tb_lagarto_plic_target_arbiter;

    localparam int NDUT = 6;
    localparam int PW   = 3;
    localparam int MAXS = 63;
    localparam int NS_T   [NDUT] = '{31, 31, 5, 63, 1, 63};
    localparam int PIPE_T [NDUT] = '{1, 0, 1, 0, 1, 1};
    localparam int TIE_T  [NDUT] = '{0, 1, 1, 0, 0, 1};

    logic             clk;
    logic             rst_n;
    logic [MAXS-1:0]  pend;
    logic [MAXS-1:0]  en;
    logic [MAXS*PW-1:0] prios;
    logic [PW-1:0]    thr;

    logic [PW-1:0] res_prio [NDUT];
    logic [7:0]    res_id   [NDUT];
    logic          res_eip  [NDUT];
    logic          res_vld  [NDUT];

    int n_chk;
    int n_bad;
    int ecnt;
    int hist_prio [NDUT][64];
    int hist_id   [NDUT][64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int NS  = NS_T[g];
        localparam int IDW = $clog2(NS + 1);
        logic [PW-1:0]  prio_w;
        logic [IDW-1:0] id_w;
        logic           eip_w;
        logic           vld_w;

        lagarto_plic_target_arbiter #(
            .NUM_SOURCES(NS),
            .PRIORITY_WIDTH(PW),
            .PIPELINED(PIPE_T[g]),
            .TIE_BREAK_LOWEST_ID(TIE_T[g])
        ) u_dut (
            .clk_i(clk),
            .rstn_i(rst_n),
            .pending_i(pend[NS-1:0]),
            .enable_i(en[NS-1:0]),
            .priorities_i(prios[NS*PW-1:0]),
            .threshold_i(thr),
            .max_priority_o(prio_w),
            .max_id_o(id_w),
            .eip_o(eip_w),
            .valid_o(vld_w)
        );

        assign res_prio[g] = prio_w;
        assign res_id[g]   = 8'(id_w);
        assign res_eip[g]  = eip_w;
        assign res_vld[g]  = vld_w;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int g);
        int d;
        d = $clog2(NS_T[g] + 1);
        if (d < 1) d = 1;
        return (PIPE_T[g] != 0) ? d : 1;
    endfunction

    // Reference: highest priority among eligible sources, then the tie rule
    // picks the lowest or highest ID among those at that priority.
    function automatic void ref_winner(input int ns, input int tie_low, output int wp, output int wid);
        int best;
        int p;
        best = 0;
        wp = 0;
        wid = 0;
        for (int k = 1; k <= ns; k++) begin
            p = int'(prios[(k-1)*PW +: PW]);
            if (pend[k-1] && en[k-1] && p > best) best = p;
        end
        if (best == 0) return;
        wp = best;
        for (int k = 1; k <= ns; k++) begin
            p = int'(prios[(k-1)*PW +: PW]);
            if (pend[k-1] && en[k-1] && p == best) begin
                if (wid == 0) wid = k;
                else if (tie_low != 0 && k < wid) wid = k;
                else if (tie_low == 0 && k > wid) wid = k;
            end
        end
    endfunction

    task automatic clear_inputs();
        pend  = '0;
        en    = '0;
        prios = '0;
        thr   = '0;
    endtask

    task automatic set_src(input int k, input int p, input logic pd, input logic e);
        pend[k-1] = pd;
        en[k-1]   = e;
        prios[(k-1)*PW +: PW] = PW'(p);
    endtask

    task automatic rand_inputs();
        int hi;
        hi    = ($urandom_range(0, 3) == 0) ? 2 : 7;
        pend  = MAXS'({$urandom, $urandom});
        en    = MAXS'({$urandom, $urandom}) | MAXS'({$urandom, $urandom});
        for (int k = 0; k < MAXS; k++) begin
            prios[k*PW +: PW] = PW'($urandom_range(0, hi));
        end
        thr = PW'($urandom_range(0, 7));
    endtask

    task automatic check_dut(input int g);
        int lat;
        logic [31:0] ep;
        logic [31:0] ei;
        logic        v;
        lat = lat_of(g);
        v   = (ecnt >= lat);
        ep  = 0;
        ei  = 0;
        if (v) begin
            ep = 32'(hist_prio[g][(ecnt - lat + 1) % 64]);
            ei = 32'(hist_id[g][(ecnt - lat + 1) % 64]);
        end
        check_val($sformatf("u%0d.prio@%0d", g, ecnt), 32'(res_prio[g]), ep);
        check_val($sformatf("u%0d.id@%0d", g, ecnt), 32'(res_id[g]), ei);
        check_val($sformatf("u%0d.vld@%0d", g, ecnt), 32'(res_vld[g]), 32'(v));
        check_val($sformatf("u%0d.eip@%0d", g, ecnt), 32'(res_eip[g]), 32'(v && (ep > 32'(thr))));
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check_val($sformatf("%s.u%0d.prio", tag, g), 32'(res_prio[g]), 0);
            check_val($sformatf("%s.u%0d.id", tag, g), 32'(res_id[g]), 0);
            check_val($sformatf("%s.u%0d.vld", tag, g), 32'(res_vld[g]), 0);
            check_val($sformatf("%s.u%0d.eip", tag, g), 32'(res_eip[g]), 0);
        end
    endtask

    // Entered just after a falling edge with inputs already driven.
    task automatic run_cycle();
        int p;
        int id;
        for (int g = 0; g < NDUT; g++) begin
            ref_winner(NS_T[g], TIE_T[g], p, id);
            hist_prio[g][(ecnt + 1) % 64] = p;
            hist_id[g][(ecnt + 1) % 64]   = id;
        end
        @(posedge clk);
        ecnt++;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check_dut(g);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, held while inputs toggle.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rand_inputs();
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        ecnt  = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        ecnt  = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset held with toggling inputs, then fill after release.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rand_inputs();
            @(posedge clk);
            #1;
            check_zero("rst_init");
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        ecnt  = 0;
        repeat (8) run_cycle();
        check_val("fill.vld_u0", 32'(res_vld[0]), 1);

        // Single source against threshold.
        clear_inputs();
        set_src(7, 3, 1'b1, 1'b1);
        thr = 3'd2;
        repeat (6) run_cycle();
        check_val("single.id_u0", 32'(res_id[0]), 7);
        check_val("single.prio_u0", 32'(res_prio[0]), 3);
        check_val("single.eip_u0", 32'(res_eip[0]), 1);
        check_val("single.eip_u1", 32'(res_eip[1]), 1);
        thr = 3'd3;
        #1;
        check_val("thr_eq.eip_u0", 32'(res_eip[0]), 0);
        check_val("thr_eq.eip_u1", 32'(res_eip[1]), 0);
        check_val("thr_eq.id_u0", 32'(res_id[0]), 7);
        thr = 3'd7;
        run_cycle();

        // Equal priorities and the tie-break direction.
        clear_inputs();
        set_src(4, 5, 1'b1, 1'b1);
        set_src(20, 5, 1'b1, 1'b1);
        repeat (6) run_cycle();
        check_val("tie.id_u0", 32'(res_id[0]), 20);
        check_val("tie.id_u1", 32'(res_id[1]), 4);
        check_val("tie.prio_u1", 32'(res_prio[1]), 5);
        set_src(9, 6, 1'b1, 1'b1);
        repeat (6) run_cycle();
        check_val("tie_hi.id_u0", 32'(res_id[0]), 9);
        check_val("tie_hi.id_u1", 32'(res_id[1]), 9);

        // Disabled and zero-priority sources never win.
        clear_inputs();
        set_src(12, 7, 1'b1, 1'b0);
        set_src(3, 0, 1'b1, 1'b1);
        repeat (6) run_cycle();
        check_val("mask.id_u0", 32'(res_id[0]), 0);
        check_val("mask.prio_u0", 32'(res_prio[0]), 0);
        check_val("mask.eip_u0", 32'(res_eip[0]), 0);
        en[11] = 1'b1;
        repeat (6) run_cycle();
        check_val("unmask.id_u0", 32'(res_id[0]), 12);
        check_val("unmask.prio_u1", 32'(res_prio[1]), 7);

        // Back-to-back winners stream out on consecutive cycles.
        for (int k = 1; k <= 4; k++) begin
            clear_inputs();
            set_src(k, 1, 1'b1, 1'b1);
            run_cycle();
        end
        clear_inputs();
        for (int k = 1; k <= 4; k++) begin
            run_cycle();
            check_val($sformatf("stream.id_u0_%0d", k), 32'(res_id[0]), 32'(k));
        end

        // Reset in the middle of a stream.
        for (int k = 1; k <= 2; k++) begin
            clear_inputs();
            set_src(k + 10, 4, 1'b1, 1'b1);
            run_cycle();
        end
        reset_mid();
        clear_inputs();
        repeat (8) run_cycle();

        // Random traffic with one reset in the middle.
        for (int c = 0; c < 10000; c++) begin
            rand_inputs();
            if (c == 5000) begin
                reset_mid();
            end
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
